// File: rtl/frac_lut_pkg.sv
// Shared types and constants for the fracturable K-LUT configuration tile.
// Build option FRAC_LUT_PARITY_EN appends one even-parity bit to the bitstream.
package frac_lut_pkg;

  typedef enum logic [1:0] {
    FLC_IDLE   = 2'd0,
    FLC_SHIFT  = 2'd1,
    FLC_COMMIT = 2'd2
  } flc_state_e;

  // Positions of the fracturing enables inside the mode field.
  localparam int MODE_K1_IDX = 0;
  localparam int MODE_K2_IDX = 1;

`ifdef FRAC_LUT_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int cfg_bits(input int k, input int mode_bits);
    return (1 << k) + mode_bits + PARITY_BITS;
  endfunction

endpackage

// File: rtl/frac_lut_tree.sv
// Combinational mux tree: one K-input tap, two (K-1)-input taps and four
// (K-2)-input taps, all read from the same truth table.
module frac_lut_tree #(
  parameter int K = 6
) (
  input  logic [2**K-1:0] i_tt,
  input  logic [K-1:0]    i_sel,
  output logic            o_lutk,
  output logic [1:0]      o_lutk1,
  output logic [3:0]      o_lutk2
);

  localparam int HALF  = 2**(K-1);
  localparam int QUART = 2**(K-2);

  logic [HALF-1:0]  w_half  [2];
  logic [QUART-1:0] w_quart [4];

  for (genvar h = 0; h < 2; h++) begin : g_half
    assign w_half[h]  = i_tt[h*HALF +: HALF];
    assign o_lutk1[h] = w_half[h][i_sel[K-2:0]];
  end

  for (genvar q = 0; q < 4; q++) begin : g_quart
    assign w_quart[q] = i_tt[q*QUART +: QUART];
    assign o_lutk2[q] = w_quart[q][i_sel[K-3:0]];
  end

  // The full-width tap is the top stage of the tree: the MSB picks a half.
  assign o_lutk = w_half[i_sel[K-1]][i_sel[K-2:0]];

endmodule

// File: rtl/frac_lutk_cfg.sv
// Fracturable K-LUT with shadow/active double-buffered configuration chain and
// length-checked commit. FRAC_LUT_PARITY_EN adds a trailing even-parity bit.
module frac_lutk_cfg
  import frac_lut_pkg::*;
#(
  parameter int K         = 6,
  parameter int MODE_BITS = 2
) (
  input  logic         prog_clk,
  input  logic         pReset_n,
  input  logic         cfg_en,
  input  logic         ccff_head,
  output logic         ccff_tail,
  input  logic [K-1:0] frac_lut_in,
  output logic         lutk_out,
  output logic [1:0]   lutk1_out,
  output logic [3:0]   lutk2_out,
  output logic         cfg_valid,
  output logic         cfg_done,
  output logic         cfg_err
);

  localparam int TT_BITS  = 2**K;
  localparam int ACT_BITS = TT_BITS + MODE_BITS;
  localparam int CFG_BITS = cfg_bits(K, MODE_BITS);
  localparam int CNT_W    = $clog2(CFG_BITS + 1) + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

  flc_state_e            r_state;
  logic [CFG_BITS-1:0]   r_shadow;
  logic [ACT_BITS-1:0]   r_active;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_valid;
  logic                  r_done;
  logic                  r_err;

  logic [CFG_BITS-1:0]   w_shift;
  logic [MODE_BITS-1:0]  w_mode;
  logic                  w_parity_ok;
  logic                  w_commit_ok;
  logic                  w_lutk;
  logic [1:0]            w_k1;
  logic [3:0]            w_k2;

  assign w_shift = {r_shadow[CFG_BITS-2:0], ccff_head};

`ifdef FRAC_LUT_PARITY_EN
  assign w_parity_ok = ~^r_shadow;
`else
  assign w_parity_ok = 1'b1;
`endif

  assign w_commit_ok = (r_cnt == CNT_FULL) && w_parity_ok;

  // NOTE: all state here is updated with <= so every branch sees the values
  // from before the edge; a blocking = would let later lines see new values.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_state  <= FLC_IDLE;
      r_shadow <= '0;
      r_active <= '0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        FLC_IDLE: begin
          if (cfg_en) begin
            r_shadow <= w_shift;
            r_cnt    <= CNT_W'(1);
            r_state  <= FLC_SHIFT;
          end
        end
        FLC_SHIFT: begin
          if (cfg_en) begin
            r_shadow <= w_shift;
            if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_state <= FLC_COMMIT;
          end
        end
        FLC_COMMIT: begin
          // Payload sits in the oldest bits; a parity bit, if present, is bit 0.
          if (w_commit_ok) begin
            r_active <= r_shadow[CFG_BITS-1 -: ACT_BITS];
            r_done   <= 1'b1;
            r_valid  <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
          r_state <= FLC_IDLE;
        end
        default: r_state <= FLC_IDLE;
      endcase
    end
  end

  assign w_mode = r_active[TT_BITS +: MODE_BITS];

  frac_lut_tree #(.K(K)) u_tree (
    .i_tt    (r_active[TT_BITS-1:0]),
    .i_sel   (frac_lut_in),
    .o_lutk  (w_lutk),
    .o_lutk1 (w_k1),
    .o_lutk2 (w_k2)
  );

  assign lutk_out  = w_lutk;
  assign lutk1_out = w_k1 & {2{w_mode[MODE_K1_IDX]}};
  assign lutk2_out = w_k2 & {4{w_mode[MODE_K2_IDX]}};
  assign ccff_tail = r_shadow[CFG_BITS-1];
  assign cfg_valid = r_valid;
  assign cfg_done  = r_done;
  assign cfg_err   = r_err;

endmodule
